// File: rtl/vision_pkg.sv
// Shared definitions for the vision pixel pipeline: sequencer states, RGB565 constants and count widths.
package vision_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VSYNC,
    CAPTURE,
    SKIP,
    DONE
  } vseq_state_t;

  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLACK = 16'h0000;

  localparam int X_CNT_W    = 10;
  localparam int Y_CNT_W    = 9;
  localparam int SKIP_CNT_W = 8;

endpackage

// File: rtl/byte_pair_assembler.sv
// Pairs camera bytes into RGB565 words and strobes each accepted pixel one cycle after its second byte.
// VISION_SEQ_BYTE_SWAP_EN: the first byte of each pair lands in [7:0] instead of [15:8].
module byte_pair_assembler
  import vision_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_i,
  input  logic        line_end_i,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  output logic        complete_o,
  output logic        odd_o,
  output logic        strobe_o,
  output logic [15:0] pixel_o
);
  logic        phase_q, phase_d;
  logic [7:0]  first_q, first_d;
  logic        strobe_q, strobe_d;
  logic [15:0] pixel_q, pixel_d;

  assign complete_o = sample_i && phase_q;
  assign odd_o      = line_end_i && phase_q;
  assign strobe_o   = strobe_q;
  assign pixel_o    = pixel_q;

  always_comb begin
    phase_d  = phase_q;
    first_d  = first_q;
    strobe_d = 1'b0;
    pixel_d  = pixel_q;
    if (line_end_i) begin
      phase_d = 1'b0;
    end else if (sample_i) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        first_d = data_i;
      end else if (accept_i) begin
        strobe_d = 1'b1;
`ifdef VISION_SEQ_BYTE_SWAP_EN
        pixel_d = {data_i, first_q};
`else
        pixel_d = {first_q, data_i};
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= 1'b0;
      first_q  <= 8'h00;
      strobe_q <= 1'b0;
      pixel_q  <= BLACK;
    end else begin
      phase_q  <= phase_d;
      first_q  <= first_d;
      strobe_q <= strobe_d;
      pixel_q  <= pixel_d;
    end
  end

endmodule

// File: rtl/vision_frame_sequencer.sv
// Aligns the camera byte stream to vsync, forwards every (SKIP_FRAMES+1)th frame as counted RGB565 pixels,
// and flags malformed frames. Byte order is selected inside byte_pair_assembler by VISION_SEQ_BYTE_SWAP_EN.
module vision_frame_sequencer
  import vision_pkg::*;
#(
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int SKIP_FRAMES  = 0
) (
  input  logic               pixel_clock_in,
  input  logic               reset,
  input  logic               enable,
  input  logic               vsync,
  input  logic               href,
  input  logic [7:0]         cam_data,
  output logic [X_CNT_W-1:0] frame_x_count,
  output logic [Y_CNT_W-1:0] frame_y_count,
  output logic [15:0]        pixel_data,
  output logic               pixel_valid,
  output logic               frame_start,
  output logic               frame_done,
  output logic               frame_error,
  output logic               busy
);
  localparam logic [X_CNT_W-1:0]    WIDTH_L  = X_CNT_W'(FRAME_WIDTH);
  localparam logic [Y_CNT_W-1:0]    HEIGHT_L = Y_CNT_W'(FRAME_HEIGHT);
  localparam logic [SKIP_CNT_W-1:0] SKIP_L   = SKIP_CNT_W'(SKIP_FRAMES);

  vseq_state_t           state_q, state_d;
  logic                  vsync_q, href_q;
  logic [X_CNT_W-1:0]    x_q, x_d;
  logic [Y_CNT_W-1:0]    y_q, y_d;
  logic [SKIP_CNT_W-1:0] skip_q, skip_d;
  logic                  err_q, err_d;
  logic                  pend_q, pend_d;
  logic                  frame_start_q, frame_done_q, frame_error_q, busy_q;

  logic vsync_rise, vsync_fall, href_fall;
  logic pair_complete, odd_drop, in_range, accept;
  logic [X_CNT_W-1:0] x_line_end;

  assign vsync_rise = vsync && !vsync_q;
  assign vsync_fall = !vsync && vsync_q;
  assign href_fall  = !href && href_q;
  assign in_range   = (x_q < WIDTH_L) && (y_q < HEIGHT_L);
  assign accept     = (state_q == CAPTURE) && in_range;
  // A strobe still in flight when href drops has not yet advanced x.
  assign x_line_end = x_q + X_CNT_W'(pixel_valid);

  byte_pair_assembler u_pair (
    .clk        (pixel_clock_in),
    .rst        (reset),
    .sample_i   (href),
    .line_end_i (href_fall),
    .accept_i   (accept),
    .data_i     (cam_data),
    .complete_o (pair_complete),
    .odd_o      (odd_drop),
    .strobe_o   (pixel_valid),
    .pixel_o    (pixel_data)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    skip_d  = skip_q;
    err_d   = err_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: if (enable) state_d = WAIT_VSYNC;
      WAIT_VSYNC: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (vsync_fall) begin
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = (skip_q != '0) ? SKIP : CAPTURE;
        end
      end
      CAPTURE: begin
        if (pixel_valid) x_d = x_q + X_CNT_W'(1);
        if (href_fall) begin
          x_d = '0;
          if (y_q < HEIGHT_L) y_d = y_q + Y_CNT_W'(1);
          if (odd_drop || (x_line_end != WIDTH_L)) err_d = 1'b1;
        end
        if (pair_complete && !in_range) err_d = 1'b1;
        if (vsync_rise && (y_q != HEIGHT_L)) err_d = 1'b1;
        // A final pixel landing with the vsync rise is strobed before DONE.
        if (vsync_rise && pair_complete) begin
          pend_d = 1'b1;
        end else if (vsync_rise || pend_q) begin
          pend_d  = 1'b0;
          state_d = DONE;
        end
      end
      SKIP: begin
        if (vsync_rise) begin
          skip_d  = skip_q - SKIP_CNT_W'(1);
          state_d = WAIT_VSYNC;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        skip_d  = SKIP_L;
        state_d = enable ? WAIT_VSYNC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock_in or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      skip_q        <= '0;
      err_q         <= 1'b0;
      pend_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync;
      href_q        <= href;
      x_q           <= x_d;
      y_q           <= y_d;
      skip_q        <= skip_d;
      err_q         <= err_d;
      pend_q        <= pend_d;
      frame_start_q <= pair_complete && accept && (x_q == '0) && (y_q == '0);
      frame_done_q  <= (state_d == DONE);
      frame_error_q <= (state_d == DONE) && err_d;
      busy_q        <= (state_d != IDLE);
    end
  end

  assign frame_x_count = x_q;
  assign frame_y_count = y_q;
  assign frame_start   = frame_start_q;
  assign frame_done    = frame_done_q;
  assign frame_error   = frame_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vision_frame_sequencer.sv
// Directed bench for vision_frame_sequencer on a 16x12 frame; a second instance covers frame skipping.
module tb_vision_frame_sequencer;
  localparam int W = 16;
  localparam int H = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic en2 = 1'b0;
  logic vsync = 1'b1;
  logic href = 1'b0;
  logic [7:0] cam_data = 8'h00;

  logic [9:0] x, x2;
  logic [8:0] y, y2;
  logic [15:0] pd, pd2;
  logic pv, pv2, fs, fs2, fd, fd2, fe, fe2, busy, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vision_frame_sequencer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SKIP_FRAMES(0)) dut (
    .pixel_clock_in(clk), .reset(reset), .enable(enable), .vsync(vsync), .href(href),
    .cam_data(cam_data), .frame_x_count(x), .frame_y_count(y), .pixel_data(pd),
    .pixel_valid(pv), .frame_start(fs), .frame_done(fd), .frame_error(fe), .busy(busy)
  );

  vision_frame_sequencer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SKIP_FRAMES(2)) dut_skip (
    .pixel_clock_in(clk), .reset(reset), .enable(en2), .vsync(vsync), .href(href),
    .cam_data(cam_data), .frame_x_count(x2), .frame_y_count(y2), .pixel_data(pd2),
    .pixel_valid(pv2), .frame_start(fs2), .frame_done(fd2), .frame_error(fe2), .busy(busy2)
  );

  // Output monitor for the main instance
  logic mon_clr = 1'b0;
  logic [15:0] exp_px = 16'h07E0;
  int n_strobe, n_start, n_done, px_bad, coord_bad, start_bad;
  int line_cnt[16];
  logic last_err;
  logic [9:0] max_x, prev_x;
  logic [8:0] prev_y;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_strobe <= 0; n_start <= 0; n_done <= 0; px_bad <= 0; coord_bad <= 0; start_bad <= 0;
      last_err <= 1'b0; max_x <= '0; prev_x <= '0; prev_y <= 9'h1FF;
      for (int i = 0; i < 16; i++) line_cnt[i] <= 0;
    end else begin
      if (pv) begin
        n_strobe <= n_strobe + 1;
        if (y < 9'd16) line_cnt[y[3:0]] <= line_cnt[y[3:0]] + 1;
        if (pd !== exp_px) px_bad <= px_bad + 1;
        if ((y != prev_y) ? (x != 10'd0) : (x != prev_x + 10'd1)) coord_bad <= coord_bad + 1;
        prev_x <= x;
        prev_y <= y;
        if (x > max_x) max_x <= x;
      end
      if (fs) begin
        n_start <= n_start + 1;
        if (!(pv && x == 10'd0 && y == 9'd0)) start_bad <= start_bad + 1;
      end
      if (fd) begin
        n_done <= n_done + 1;
        last_err <= fe;
        $display("frame_done: error=%0b strobes=%0d", fe, n_strobe);
      end
    end
  end

  // Monitor for the skipping instance
  int n2_strobe = 0, n2_done = 0, n2_start = 0, bad2 = 0;
  always @(negedge clk) begin
    if (pv2) n2_strobe <= n2_strobe + 1;
    if (fd2) n2_done <= n2_done + 1;
    if (fs2) n2_start <= n2_start + 1;
    if ((pv2 && (x2 > 10'd15 || y2 > 9'd11 || pd2 !== 16'h07E0)) || (fd2 && fe2)) bad2 <= bad2 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  task automatic clear_mon;
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    @(negedge clk);
  endtask

  // Drives one frame from vsync high; returns early at stop_line/stop_len or with sync_last.
  task automatic send_frame(input int short_line, input int short_len, input int drop_line,
                            input int stop_line, input int stop_len, input bit sync_last,
                            input logic [7:0] b0, input logic [7:0] b1);
    vsync = 1'b1; href = 1'b0;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < H; l++) begin
      int n;
      n = (l == short_line) ? short_len : 2 * W;
      if (l == stop_line) n = stop_len;
      if (l == drop_line) enable = 1'b0;
      for (int b = 0; b < n; b++) begin
        href = 1'b1;
        cam_data = (b % 2 == 0) ? b0 : b1;
        if (sync_last && l == H - 1 && b == n - 1) vsync = 1'b1;
        @(negedge clk);
      end
      if (l == stop_line || (sync_last && l == H - 1)) return;
      href = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if ({pv, fs, fd, fe, busy, x, y, pd} !== 40'd0) begin errors++;
      $display("FAIL reset_outputs: got %h required 0", {pv, fs, fd, fe, busy, x, y, pd}); end
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_after_enable: got %b required 1", busy); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_skip_idle: got %b required 0", busy2); end
  endtask

  task automatic test_clean_frame;
    clear_mon();
    exp_px = 16'h07E0;
    send_frame(-1, 0, -1, -1, 0, 1'b0, 8'h07, 8'hE0);
    vsync = 1'b1;
    @(negedge clk);
    checks++; if ({fd, fe} !== 2'b10) begin errors++; $display("FAIL clean_done_timing: got done/err %b required 10", {fd, fe}); end
    @(negedge clk);
    checks++; if (fd !== 1'b0) begin errors++; $display("FAIL clean_done_pulse: got %b required 0", fd); end
    repeat (3) @(negedge clk);
    checks++; if (n_strobe !== 192) begin errors++; $display("FAIL clean_strobes: got %0d required 192", n_strobe); end
    checks++; if (n_start !== 1 || start_bad !== 0) begin errors++; $display("FAIL clean_start: got %0d (bad %0d) required 1", n_start, start_bad); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL clean_done_count: got %0d required 1", n_done); end
    checks++; if (px_bad !== 0) begin errors++; $display("FAIL clean_pixels: got %0d bad required 0", px_bad); end
    checks++; if (coord_bad !== 0) begin errors++; $display("FAIL clean_coords: got %0d bad required 0", coord_bad); end
    checks++; if (line_cnt[11] !== 16 || max_x !== 10'd15) begin errors++;
      $display("FAIL clean_extent: got line11=%0d max_x=%0d required 16/15", line_cnt[11], max_x); end
  endtask

  task automatic test_byte_order;
    clear_mon();
`ifdef VISION_SEQ_BYTE_SWAP_EN
    exp_px = 16'h3CA5;
`else
    exp_px = 16'hA53C;
`endif
    send_frame(-1, 0, -1, -1, 0, 1'b0, 8'hA5, 8'h3C);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (px_bad !== 0 || n_strobe !== 192) begin errors++;
      $display("FAIL byte_order: got bad=%0d strobes=%0d required 0/192", px_bad, n_strobe); end
    checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL byte_order_err: got %b required 0", last_err); end
    exp_px = 16'h07E0;
  endtask

  task automatic test_odd_line;
    clear_mon();
    send_frame(3, 31, -1, -1, 0, 1'b0, 8'h07, 8'hE0);
    vsync = 1'b1;
    @(negedge clk);
    checks++; if ({fd, fe} !== 2'b11) begin errors++; $display("FAIL odd_done_err: got %b required 11", {fd, fe}); end
    repeat (3) @(negedge clk);
    checks++; if (line_cnt[3] !== 15) begin errors++; $display("FAIL odd_line3: got %0d required 15", line_cnt[3]); end
    checks++; if (n_strobe !== 191) begin errors++; $display("FAIL odd_strobes: got %0d required 191", n_strobe); end
    checks++; if (px_bad !== 0 || coord_bad !== 0) begin errors++;
      $display("FAIL odd_data: got px_bad=%0d coord_bad=%0d required 0/0", px_bad, coord_bad); end
  endtask

  task automatic test_long_line;
    clear_mon();
    send_frame(5, 36, -1, -1, 0, 1'b0, 8'h07, 8'hE0);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (line_cnt[5] !== 16) begin errors++; $display("FAIL long_line5: got %0d required 16", line_cnt[5]); end
    checks++; if (max_x !== 10'd15) begin errors++; $display("FAIL long_max_x: got %0d required 15", max_x); end
    checks++; if (n_strobe !== 192) begin errors++; $display("FAIL long_strobes: got %0d required 192", n_strobe); end
    checks++; if (n_done !== 1 || last_err !== 1'b1) begin errors++;
      $display("FAIL long_err: got done=%0d err=%b required 1/1", n_done, last_err); end
  endtask

  task automatic test_back_to_back;
    clear_mon();
    send_frame(-1, 0, -1, -1, 0, 1'b1, 8'h07, 8'hE0);
    checks++; if ({pv, fd, x, y} !== {1'b1, 1'b0, 10'd15, 9'd11}) begin errors++;
      $display("FAIL sync_last_strobe: got pv=%b done=%b x=%0d y=%0d required 1/0/15/11", pv, fd, x, y); end
    href = 1'b0;
    @(negedge clk);
    checks++; if ({fd, fe} !== 2'b11) begin errors++; $display("FAIL sync_last_done: got %b required 11", {fd, fe}); end
    repeat (3) @(negedge clk);
    checks++; if (n_strobe !== 192) begin errors++; $display("FAIL sync_last_strobes: got %0d required 192", n_strobe); end
  endtask

  task automatic test_enable_drop;
    clear_mon();
    send_frame(-1, 0, 5, -1, 0, 1'b0, 8'h07, 8'hE0);
    vsync = 1'b1;
    @(negedge clk);
    checks++; if ({fd, fe} !== 2'b10) begin errors++; $display("FAIL endrop_done: got %b required 10", {fd, fe}); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy: got %b required 0", busy); end
    repeat (2) @(negedge clk);
    checks++; if (n_strobe !== 192) begin errors++; $display("FAIL endrop_strobes: got %0d required 192", n_strobe); end
    clear_mon();
    send_frame(-1, 0, -1, -1, 0, 1'b0, 8'h07, 8'hE0);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (n_strobe !== 0 || n_done !== 0) begin errors++;
      $display("FAIL endrop_idle_frame: got strobes=%0d done=%0d required 0/0", n_strobe, n_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_idle_busy: got %b required 0", busy); end
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_skip;
    int exp_s[5];
    int exp_d[5];
    int s0, d0, f0;
    exp_s = '{192, 0, 0, 192, 0};
    exp_d = '{1, 0, 0, 1, 0};
    enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    en2 = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      s0 = n2_strobe; d0 = n2_done; f0 = n2_start;
      send_frame(-1, 0, -1, -1, 0, 1'b0, 8'h07, 8'hE0);
      vsync = 1'b1;
      repeat (4) @(negedge clk);
      $display("skip frame %0d: strobes=%0d done=%0d", f + 1, n2_strobe - s0, n2_done - d0);
      checks++; if (n2_strobe - s0 !== exp_s[f]) begin errors++;
        $display("FAIL skip_strobes_f%0d: got %0d required %0d", f + 1, n2_strobe - s0, exp_s[f]); end
      checks++; if (n2_done - d0 !== exp_d[f]) begin errors++;
        $display("FAIL skip_done_f%0d: got %0d required %0d", f + 1, n2_done - d0, exp_d[f]); end
      checks++; if (n2_start - f0 !== exp_d[f]) begin errors++;
        $display("FAIL skip_start_f%0d: got %0d required %0d", f + 1, n2_start - f0, exp_d[f]); end
    end
    checks++; if (bad2 !== 0) begin errors++; $display("FAIL skip_pixels: got %0d bad required 0", bad2); end
    en2 = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int s0;
    clear_mon();
    send_frame(-1, 0, -1, 6, 16, 1'b0, 8'h07, 8'hE0);
    checks++; if ({pv, x, y} !== {1'b1, 10'd7, 9'd6}) begin errors++;
      $display("FAIL rst_mid_position: got pv=%b x=%0d y=%0d required 1/7/6", pv, x, y); end
    reset = 1'b1;
    #1;
    checks++; if ({pv, fs, fd, fe, busy, x, y, pd} !== 40'd0) begin errors++;
      $display("FAIL rst_mid_outputs: got %h required 0", {pv, fs, fd, fe, busy, x, y, pd}); end
    @(negedge clk);
    reset = 1'b0;
    href = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d required 0", n_done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_rearm: got busy=%b required 1", busy); end
    s0 = n_strobe;
    send_frame(-1, 0, -1, -1, 0, 1'b0, 8'h07, 8'hE0);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (n_strobe - s0 !== 192) begin errors++; $display("FAIL rst_mid_resume: got %0d required 192", n_strobe - s0); end
    checks++; if (n_done !== 1 || last_err !== 1'b0) begin errors++;
      $display("FAIL rst_mid_resume_done: got done=%0d err=%b required 1/0", n_done, last_err); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_byte_order();
    test_odd_line();
    test_long_line();
    test_back_to_back();
    test_enable_drop();
    test_skip();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vision_frame_sequencer.md
# vision_frame_sequencer

Sequences the camera byte stream into the pixel interface consumed by `vision_process`. It aligns to frame boundaries using vsync, pairs bytes into RGB565 pixels, and generates `frame_x_count`/`frame_y_count`/`pixel_valid`. It optionally decimates frames so the vision datapath only processes every Nth frame. It also flags malformed frames, so downstream lane/jump results are only trusted for complete frames.

## Interface
- `FRAME_WIDTH`, 320, pixels per line; max 1023.
- `FRAME_HEIGHT`, 240, lines per frame; max 511.
- `SKIP_FRAMES`, 0, frames dropped after each forwarded frame (0 = forward every frame).
- `pixel_clock_in`  in  1  camera pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; capture permitted while high.
- `vsync`  in  1  camera vsync; high between frames.
- `href`  in  1  camera line-valid; high while line bytes are present.
- `cam_data`  in  8  camera byte; sampled when `href` is high.
- `frame_x_count`  out  10  column of the current or next pixel.
- `frame_y_count`  out  9  row of the current or next pixel.
- `pixel_data`  out  16  assembled RGB565 pixel.
- `pixel_valid`  out  1  one-cycle strobe; `pixel_data` and the counts are valid.
- `frame_start`  out  1  one-cycle pulse on the first forwarded pixel of a frame.
- `frame_done`  out  1  one-cycle pulse at the end of a forwarded frame.
- `frame_error`  out  1  valid with `frame_done`; frame was malformed.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: leave when `enable`=1 → WAIT_VSYNC.
  - WAIT_VSYNC: wait for a `vsync` falling edge, then → CAPTURE, or → SKIP if the skip counter is nonzero.
  - CAPTURE: forward pixels; `vsync` rising → DONE.
  - SKIP: ignore the data; `vsync` rising → WAIT_VSYNC and decrement the skip counter.
  - DONE: one cycle; pulse `frame_done`; reload skip counter with `SKIP_FRAMES`; → WAIT_VSYNC if `enable`, else → IDLE.
- Byte pairing:
  - A phase bit toggles on each byte sampled with `href`=1.
  - Phase 0 byte → `pixel_data[15:8]`; phase 1 byte → `[7:0]`, then strobe `pixel_valid`.
  - Phase clears on `href` falling.
- Counters: after each strobe, x increments. On `href` falling, x→0 and y increments (saturating at `FRAME_HEIGHT`).
- `frame_error` is set and held until DONE if any of these occur:
  - `href` falls with phase 1 (odd byte count); the half pixel is discarded.
  - A line ends with x≠`FRAME_WIDTH`.
  - A pixel arrives at x≥`FRAME_WIDTH` or y≥`FRAME_HEIGHT`; the strobe is suppressed.
  - `vsync` rises with y≠`FRAME_HEIGHT`.
- `enable` falling mid-frame: the current frame completes normally, then → IDLE.
- Simultaneous `vsync` rise and last byte: the pixel is strobed first, then DONE is entered on the next cycle.

## Timing
- All outputs are registered. `pixel_valid` asserts the cycle after the phase-1 byte is sampled.
- During the strobe, the counts hold that pixel's coordinates. They advance on the following edge.
- `frame_start` coincides with the strobe of pixel (0,0).
- `frame_done` asserts the cycle after `vsync` rise is detected.
- `vsync` and `href` edges are detected against a one-cycle registered copy.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - phase 0;
  - skip counter 0, so the first frame after reset is always forwarded.
- Reset mid-frame aborts immediately. No `frame_done` is emitted.

## Configuration
- `VISION_SEQ_BYTE_SWAP_EN` defined: the phase 0 byte goes to `[7:0]` and the phase 1 byte to `[15:8]`, for cameras that emit the low byte first.
- Undefined: high byte first, as described above.
- The macro has no effect on timing.

## Structure
- The shared package `vision_pkg` holds:
  - the state enum `vseq_state_t`;
  - RGB565 constants `GREEN` = 16'h07E0 and `BLACK` = 16'h0000;
  - count widths (10, 9).
- One sub-module, `byte_pair_assembler`, contains the phase bit, byte swap, odd-byte detect and strobe. The counters and FSM stay in the top module.

## Test plan
All scenarios use `FRAME_WIDTH`=16, `FRAME_HEIGHT`=12, `SKIP_FRAMES`=0 unless stated.
- Clean frame: 12 lines of 32 bytes each carrying bytes 8'h07,8'hE0 → 192 strobes of 16'h07E0 at (0,0)…(15,11); one `frame_start`; `frame_done`=1 with `frame_error`=0.
- `SKIP_FRAMES`=2, five clean frames sent → frames 1 and 4 produce strobes and `frame_done`; frames 2, 3 and 5 produce none.
- Line 3 carries 31 bytes → 15 strobes on y=3; the last half pixel is dropped; at end of frame `frame_done`=1 and `frame_error`=1.
- Line carries 36 bytes → x stops at 15; extra strobes suppressed; `frame_error`=1.
- `enable` drops at line 5 → frame completes with 192 strobes, then `busy`=0 and a following frame produces no strobes.
- `reset` pulsed at pixel (7,6) → all outputs 0 in the same cycle; no `frame_done`; capture resumes at the next `vsync` fall after `enable`.
